// File: rtl/reaction_round_control.sv
// Round controller for the reaction-time game: arms the delay counter, times the player's reaction, flags false starts.
// Optional BEST_TIME_EN macro adds a BestTime output tracking the fastest valid reaction since reset.
module reaction_round_control #(
  parameter int TIME_WIDTH = 13,
  parameter int TICK_DIV   = 50000
) (
  input  logic                  Clock,
  input  logic                  CLRN,
  input  logic                  Start,
  input  logic                  React,
  input  logic                  DelayDone,
  output logic                  DelayEnable,
  output logic                  Lamp,
  output logic [TIME_WIDTH-1:0] ReactionTime,
  output logic                  Valid,
`ifdef BEST_TIME_EN
  output logic [TIME_WIDTH-1:0] BestTime,
`endif
  output logic                  FalseStart
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]         PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0]         PRESC_ZERO = PW'(0);
  localparam logic [TIME_WIDTH-1:0] TIME_MAX   = {TIME_WIDTH{1'b1}};
  localparam logic [TIME_WIDTH-1:0] TIME_ONE   = TIME_WIDTH'(1);
  localparam logic [TIME_WIDTH-1:0] TIME_ZERO  = TIME_WIDTH'(0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_GO     = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_FOUL   = 3'd4;

  logic [2:0]            state_r, state_s;
  logic [PW-1:0]         presc_r, presc_s;
  logic [TIME_WIDTH-1:0] time_r, time_s, time_inc_s;
  logic                  start_prev_r, react_prev_r;
  logic                  start_edge_s, react_edge_s;
  logic                  react_stop_s;

  assign start_edge_s = Start & ~start_prev_r;
  assign react_edge_s = React & ~react_prev_r;
  assign time_inc_s   = time_r + TIME_ONE;

  // Next-state, prescaler and tick-count logic
  always_comb begin
    state_s      = state_r;
    presc_s      = presc_r;
    time_s       = time_r;
    react_stop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_s = ST_ARMED;
          time_s  = TIME_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // A React edge beats a simultaneous DelayDone: the player jumped the lamp.
        if (react_edge_s) begin
          state_s = ST_FOUL;
          time_s  = TIME_ZERO;
        end else if (DelayDone) begin
          state_s = ST_GO;
          presc_s = PRESC_ZERO;
          time_s  = TIME_ZERO;
        end else begin
          state_s = ST_ARMED;
        end
      end
      ST_GO: begin
        if (react_edge_s) begin
          state_s      = ST_RESULT;
          react_stop_s = 1'b1;
        end else if (presc_r == PRESC_LAST) begin
          presc_s = PRESC_ZERO;
          time_s  = time_inc_s;
          if (time_inc_s == TIME_MAX) begin
            state_s = ST_RESULT;
          end else begin
            state_s = ST_GO;
          end
        end else begin
          presc_s = presc_r + PRESC_ONE;
        end
      end
      ST_RESULT, ST_FOUL: begin
        if (start_edge_s) begin
          state_s = ST_ARMED;
          time_s  = TIME_ZERO;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        presc_s = PRESC_ZERO;
        time_s  = TIME_ZERO;
      end
    endcase
  end

  // State, counters and button history
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      state_r      <= ST_IDLE;
      presc_r      <= PRESC_ZERO;
      time_r       <= TIME_ZERO;
      start_prev_r <= 1'b0;
      react_prev_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      presc_r      <= presc_s;
      time_r       <= time_s;
      start_prev_r <= Start;
      react_prev_r <= React;
    end
  end

  assign ReactionTime = time_r;

  // Moore outputs registered from the next-state decode so they track state_r exactly
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      DelayEnable <= 1'b0;
      Lamp        <= 1'b0;
      Valid       <= 1'b0;
      FalseStart  <= 1'b0;
    end else begin
      DelayEnable <= (state_s == ST_ARMED);
      Lamp        <= (state_s == ST_GO);
      Valid       <= (state_s == ST_RESULT);
      FalseStart  <= (state_s == ST_FOUL);
    end
  end

`ifdef BEST_TIME_EN
  logic [TIME_WIDTH-1:0] best_r;
  logic                  best_load_s;

  assign best_load_s = react_stop_s && (time_r < best_r);
  assign BestTime    = best_r;

  // Only reaction-terminated rounds compete; timeouts and fouls never qualify
  always_ff @(posedge Clock or negedge CLRN) begin
    if (!CLRN) begin
      best_r <= TIME_MAX;
    end else if (best_load_s) begin
      best_r <= time_r;
    end else begin
      best_r <= best_r;
    end
  end
`endif

endmodule

// File: tb/tb_reaction_round_control.sv
// Self-checking bench for reaction_round_control: directed spec scenarios plus randomized rounds vs a round-level model.
// Exercises BestTime when compiled with BEST_TIME_EN.
module tb_reaction_round_control;
  localparam int TW   = 13;
  localparam int TICK = 4;
  localparam int TMAX = (1 << TW) - 1;

  logic          Clock = 1'b0;
  logic          CLRN;
  logic          Start, React, DelayDone;
  logic          DelayEnable, Lamp, Valid, FalseStart;
  logic [TW-1:0] ReactionTime;
`ifdef BEST_TIME_EN
  logic [TW-1:0] BestTime;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int best_m   = TMAX;

  reaction_round_control #(.TIME_WIDTH(TW), .TICK_DIV(TICK)) dut (
    .Clock(Clock), .CLRN(CLRN), .Start(Start), .React(React), .DelayDone(DelayDone),
    .DelayEnable(DelayEnable), .Lamp(Lamp), .ReactionTime(ReactionTime), .Valid(Valid),
`ifdef BEST_TIME_EN
    .BestTime(BestTime),
`endif
    .FalseStart(FalseStart)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_best();
`ifdef BEST_TIME_EN
    check("best_time", BestTime, best_m);
`endif
  endtask

  // mode: 0 normal, 1 React held through GO entry, 2 false start, 3 false start with DelayDone same cycle
  task automatic run_round(input int dly, input int r, input int mode);
    int exp_t;
    exp_t = 0;
    React = (mode == 1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("armed_en", DelayEnable, 1);
    check("armed_time", ReactionTime, 0);
    repeat (dly) step();
    if (mode >= 2) begin
      React = 1'b1;
      DelayDone = (mode == 3);
      step();
      React = 1'b0;
      DelayDone = 1'b0;
      check("foul_flag", FalseStart, 1);
      check("foul_en", DelayEnable, 0);
      check("foul_lamp", Lamp, 0);
      check("foul_time", ReactionTime, 0);
    end else begin
      DelayDone = 1'b1;
      step();
      DelayDone = 1'b0;
      check("go_lamp", Lamp, 1);
      check("go_en", DelayEnable, 0);
      for (int i = 0; i < r; i++) begin
        React = (mode == 1) && (i < r - 1);
        step();
      end
      check("go_lamp_held", Lamp, 1);
      check("go_count", ReactionTime, r / TICK);
      exp_t = r / TICK;
      React = 1'b1;
      step();
      React = 1'b0;
      check("res_valid", Valid, 1);
      check("res_lamp", Lamp, 0);
      check("res_en", DelayEnable, 0);
      check("res_time", ReactionTime, exp_t);
      if (exp_t < best_m) best_m = exp_t;
    end
    check_best();
    // idle cycles with stray DelayDone noise; the result must not move
    repeat (3) begin
      DelayDone = 1'($urandom_range(0, 1));
      step();
    end
    DelayDone = 1'b0;
    check("hold_valid", Valid, (mode < 2) ? 1 : 0);
    check("hold_flag", FalseStart, (mode >= 2) ? 1 : 0);
    check("hold_time", ReactionTime, exp_t);
    check_best();
  endtask

  task automatic run_timeout();
    int n;
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (5) step();
    DelayDone = 1'b1;
    step();
    DelayDone = 1'b0;
    n = 0;
    while (!Valid && n < TMAX * TICK + 20) begin
      step();
      n++;
    end
    check("to_cycles", n, TMAX * TICK);
    check("to_valid", Valid, 1);
    check("to_time", ReactionTime, TMAX);
    check("to_lamp", Lamp, 0);
    check_best();
  endtask

  initial begin
    CLRN = 1'b0;
    Start = 1'b0;
    React = 1'b0;
    DelayDone = 1'b0;
    #12;
    check("rst_en", DelayEnable, 0);
    check("rst_lamp", Lamp, 0);
    check("rst_valid", Valid, 0);
    check("rst_foul", FalseStart, 0);
    check("rst_time", ReactionTime, 0);
    check_best();
    CLRN = 1'b1;
    DelayDone = 1'b1;
    React = 1'b1;
    repeat (2) step();
    React = 1'b0;
    DelayDone = 1'b0;
    step();
    check("idle_en", DelayEnable, 0);
    check("idle_lamp", Lamp, 0);

    run_round(20, 42, 0);
    run_round(3, 0, 2);
    run_round(6, 0, 3);
    run_round(0, 0, 3);
    run_round(10, 8, 1);
    run_round(4, 40, 0);
    run_round(2, 28, 0);
    run_round(7, 48, 0);
    run_round(5, 0, 2);
    run_timeout();

    for (int k = 0; k < 20; k++) begin
      int m;
      m = $urandom_range(0, 9);
      run_round($urandom_range(0, 30), $urandom_range(2, 60),
                (m < 5) ? 0 : (m < 7) ? 1 : (m < 9) ? 2 : 3);
    end

    // reset in the middle of a GO phase
    Start = 1'b1;
    step();
    Start = 1'b0;
    repeat (4) step();
    DelayDone = 1'b1;
    step();
    DelayDone = 1'b0;
    repeat (9) step();
    check("pre_rst_lamp", Lamp, 1);
    #2 CLRN = 1'b0;
    #1;
    best_m = TMAX;
    check("mrst_lamp", Lamp, 0);
    check("mrst_en", DelayEnable, 0);
    check("mrst_valid", Valid, 0);
    check("mrst_time", ReactionTime, 0);
    check_best();
    #3 CLRN = 1'b1;
    repeat (5) step();
    check("post_rst_en", DelayEnable, 0);
    check("post_rst_lamp", Lamp, 0);
    run_round(8, 21, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
